score_counter_bcd: RTL and testbench

- Parametrised multi-digit BCD score counter with per-digit seven-segment outputs for the HEX displays.
- Generalises the single-digit score state machines into one N-digit block with:
  - internal carry ripple
  - selectable saturate or wrap at the maximum count
  - leading-zero blanking
  - a high-score register
- Sits between game logic (pipe-passed pulse, game-over pulse) and the HEX display pins.

---
 rtl/score_pkg.sv | 44 ++++
 rtl/bcd_digit_cell.sv | 26 ++
 rtl/score_counter_bcd.sv | 89 ++++++++
 tb/tb_score_counter_bcd.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
// Shared types, segment table and helpers for the BCD score counter.
package score_pkg;

    typedef logic [3:0] bcd_digit_t;

    // Active-high gfedcba; entry 10 is blank.
    localparam logic [6:0] SEG_LUT [0:10] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111, 7'b0000000
    };

    function automatic logic [6:0] to_seg(
        input bcd_digit_t bcd,
        input logic       blank,
        input logic       active_low
    );
        logic [6:0] s;
        if (blank || bcd > 4'd9)
            s = SEG_LUT[10];
        else
            s = SEG_LUT[bcd];
        return active_low ? ~s : s;
    endfunction

    function automatic logic bcd_gt(
        input logic [23:0] a,
        input logic [23:0] b,
        input int          n
    );
        logic gt;
        logic done;
        gt   = 1'b0;
        done = 1'b0;
        for (int k = 5; k >= 0; k--) begin
            if (k < n && !done && a[4*k +: 4] != b[4*k +: 4]) begin
                gt   = a[4*k +: 4] > b[4*k +: 4];
                done = 1'b1;
            end
        end
        return gt;
    endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD digit register with ripple carry.
module bcd_digit_cell
    import score_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       carry_in,
    output logic [3:0] digit,
    output logic       carry_out,
    output logic       at_nine
);

    assign at_nine   = (digit == 4'd9);
    assign carry_out = carry_in && at_nine;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            digit <= '0;
        else if (clear)
            digit <= '0;
        else if (carry_in)
            digit <= at_nine ? 4'd0 : digit + 4'd1;
    end

endmodule

// File: rtl/score_counter_bcd.sv
// N-digit BCD score counter with high-score register and
// seven-segment decode for both values.
module score_counter_bcd
    import score_pkg::*;
#(
    parameter int NUM_DIGITS     = 3,
    parameter bit SATURATE       = 1,
    parameter bit BLANK_LEADING  = 1,
    parameter bit ACTIVE_LOW_SEG = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    incr,
    input  logic                    latch_hi,
    output logic [4*NUM_DIGITS-1:0] score_bcd,
    output logic [7*NUM_DIGITS-1:0] score_seg,
    output logic [7*NUM_DIGITS-1:0] hi_seg,
    output logic                    at_max,
    output logic                    wrapped
);

    logic [NUM_DIGITS:0]     carry;
    logic [NUM_DIGITS-1:0]   nine;
    logic [4*NUM_DIGITS-1:0] hi;
    logic [NUM_DIGITS-1:0]   s_blank;
    logic [NUM_DIGITS-1:0]   h_blank;
    logic [23:0]             score_ext;
    logic [23:0]             hi_ext;
    logic                    all_nine;

    assign all_nine = &nine;
    assign at_max   = all_nine;

    // Saturation blocks the increment before it enters the ripple.
    assign carry[0] = incr && !(SATURATE && all_nine);

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
        bcd_digit_cell u_cell (
            .clk       (clk),
            .reset     (reset),
            .clear     (clear),
            .carry_in  (carry[k]),
            .digit     (score_bcd[4*k +: 4]),
            .carry_out (carry[k+1]),
            .at_nine   (nine[k])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            wrapped <= 1'b0;
        else
            wrapped <= !SATURATE && carry[NUM_DIGITS] && !clear;
    end

    assign score_ext = 24'(score_bcd);
    assign hi_ext    = 24'(hi);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            hi <= '0;
        else if (latch_hi && bcd_gt(score_ext, hi_ext, NUM_DIGITS))
            hi <= score_bcd;
    end

    always_comb begin
        logic s_run;
        logic h_run;
        s_run   = 1'b1;
        h_run   = 1'b1;
        s_blank = '0;
        h_blank = '0;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            s_run      = s_run && (score_bcd[4*k +: 4] == 4'd0);
            h_run      = h_run && (hi[4*k +: 4] == 4'd0);
            s_blank[k] = BLANK_LEADING && s_run;
            h_blank[k] = BLANK_LEADING && h_run;
        end
    end

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_seg
        assign score_seg[7*k +: 7] =
            to_seg(score_bcd[4*k +: 4], s_blank[k], ACTIVE_LOW_SEG);
        assign hi_seg[7*k +: 7] =
            to_seg(hi[4*k +: 4], h_blank[k], ACTIVE_LOW_SEG);
    end

endmodule

// File: tb/tb_score_counter_bcd.sv
// Bench for score_counter_bcd: saturating and wrapping instances
// driven together and checked against an integer score model.
module tb_score_counter_bcd;

    localparam int MAXV = 999;

    localparam logic [6:0] ENC [10] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111
    };

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic clear = 1'b0;
    logic incr = 1'b0;
    logic latch_hi = 1'b0;

    logic [11:0] s_bcd, w_bcd;
    logic [20:0] s_seg, w_seg, s_hi, w_hi;
    logic        s_max, w_max, s_wr, w_wr;

    int errors = 0;
    int checks = 0;

    int ms = 0, mw = 0, hs = 0, hw = 0;
    logic wr = 1'b0;

    always #5 clk = ~clk;

    score_counter_bcd #(.NUM_DIGITS(3), .SATURATE(1)) dut_s (
        .clk(clk), .reset(reset), .clear(clear), .incr(incr),
        .latch_hi(latch_hi), .score_bcd(s_bcd), .score_seg(s_seg),
        .hi_seg(s_hi), .at_max(s_max), .wrapped(s_wr)
    );

    score_counter_bcd #(.NUM_DIGITS(3), .SATURATE(0)) dut_w (
        .clk(clk), .reset(reset), .clear(clear), .incr(incr),
        .latch_hi(latch_hi), .score_bcd(w_bcd), .score_seg(w_seg),
        .hi_seg(w_hi), .at_max(w_max), .wrapped(w_wr)
    );

    function automatic logic [11:0] to_bcd(input int v);
        return 12'(((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + v % 10);
    endfunction

    function automatic logic [20:0] seg_of(input int v);
        logic [20:0] r;
        logic [6:0]  s;
        int p;
        p = 1;
        r = '0;
        for (int k = 0; k < 3; k++) begin
            s = (k > 0 && v < p) ? 7'b0 : ENC[(v / p) % 10];
            r[7*k +: 7] = ~s;
            p = p * 10;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            ms <= 0; mw <= 0; hs <= 0; hw <= 0; wr <= 1'b0;
        end else begin
            if (latch_hi && ms > hs) hs <= ms;
            if (latch_hi && mw > hw) hw <= mw;
            wr <= 1'b0;
            if (clear) begin
                ms <= 0;
                mw <= 0;
            end else if (incr) begin
                ms <= (ms == MAXV) ? MAXV : ms + 1;
                if (mw == MAXV) begin
                    mw <= 0;
                    wr <= 1'b1;
                end else begin
                    mw <= mw + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        check("s_bcd", 32'(s_bcd), 32'(to_bcd(ms)));
        check("s_seg", 32'(s_seg), 32'(seg_of(ms)));
        check("s_hi", 32'(s_hi), 32'(seg_of(hs)));
        check("s_max", 32'(s_max), 32'(ms == MAXV));
        check("s_wr", 32'(s_wr), 32'(0));
        check("w_bcd", 32'(w_bcd), 32'(to_bcd(mw)));
        check("w_seg", 32'(w_seg), 32'(seg_of(mw)));
        check("w_hi", 32'(w_hi), 32'(seg_of(hw)));
        check("w_max", 32'(w_max), 32'(mw == MAXV));
        check("w_wr", 32'(w_wr), 32'(wr));
    end

    task automatic step(input logic c, input logic i, input logic l);
        @(negedge clk);
        clear    = c;
        incr     = i;
        latch_hi = l;
        @(posedge clk);
        #1;
    endtask

    task automatic count(input int n);
        repeat (n) step(1'b0, 1'b1, 1'b0);
    endtask

    localparam logic [20:0] RST_SEG = {7'h7f, 7'h7f, 7'b1000000};
    localparam logic [20:0] HI42 = {7'h7f, 7'b0011001, 7'b0100100};
    localparam logic [20:0] HI43 = {7'h7f, 7'b0011001, 7'b0110000};
    localparam logic [20:0] HI99 = {7'h7f, 7'b0010000, 7'b0010000};

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_bcd", 32'(s_bcd), 32'h000);
        check("rst_seg", 32'(s_seg), 32'(RST_SEG));
        check("rst_hi", 32'(w_hi), 32'(RST_SEG));
        check("rst_max", 32'(s_max), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        count(10);
        check("cnt10_bcd", 32'(s_bcd), 32'h010);
        check("cnt10_seg", 32'(s_seg), 32'({7'h7f, 7'b1111001, 7'b1000000}));
        count(5);
        check("cnt15_bcd", 32'(w_bcd), 32'h015);
        check("cnt15_ones", 32'(s_seg[6:0]), 32'(7'b0010010));

        step(1'b1, 1'b0, 1'b0);
        count(999);
        check("sat999", 32'(s_bcd), 32'h999);
        check("max999", 32'(s_max), 32'd1);
        check("wrap999", 32'(w_bcd), 32'h999);
        count(1);
        check("sat_hold", 32'(s_bcd), 32'h999);
        check("wrap_zero", 32'(w_bcd), 32'h000);
        check("wrap_pulse", 32'(w_wr), 32'd1);
        step(1'b0, 1'b0, 1'b0);
        check("wrap_gone", 32'(w_wr), 32'd0);

        step(1'b1, 1'b0, 1'b0);
        count(42);
        step(1'b0, 1'b0, 1'b1);
        check("hi42", 32'(s_hi), 32'(HI42));
        step(1'b1, 1'b0, 1'b0);
        count(17);
        step(1'b0, 1'b0, 1'b1);
        check("hi_lower", 32'(s_hi), 32'(HI42));
        count(25);
        step(1'b0, 1'b0, 1'b1);
        check("hi_equal", 32'(w_hi), 32'(HI42));
        count(1);
        step(1'b0, 1'b0, 1'b1);
        check("hi43", 32'(s_hi), 32'(HI43));

        step(1'b1, 1'b0, 1'b0);
        count(99);
        step(1'b1, 1'b1, 1'b0);
        check("clr_incr", 32'(s_bcd), 32'h000);
        count(99);
        step(1'b0, 1'b1, 1'b1);
        check("latch_incr_bcd", 32'(s_bcd), 32'h100);
        check("latch_incr_hi", 32'(s_hi), 32'(HI99));

        count(289);
        check("at389", 32'(s_bcd), 32'h389);
        @(negedge clk);
        incr = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("async_bcd", 32'(s_bcd), 32'h000);
        check("async_seg", 32'(w_seg), 32'(RST_SEG));
        check("async_hi", 32'(s_hi), 32'(RST_SEG));
        check("async_max", 32'(w_max), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        count(3);
        check("after_rst", 32'(s_bcd), 32'h003);
        step(1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
